// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Function : execute-stage operand steering for the external adder, flag
//            generation and a 2-entry result FIFO for writeback.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [RD_W-1:0]  in_rd,
  output logic [WIDTH-1:0] add_inp1,
  output logic [WIDTH-1:0] add_inp2,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wen,
  output logic [3:0]       out_flags,
  output logic             out_illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  logic [WIDTH-1:0] w_opb;
  logic             w_wen;
  logic             w_illegal;
  logic [3:0]       w_flags;
  logic [WIDTH-1:0] w_result;
  logic             w_n, w_z, w_c, w_v;
  logic             w_push, w_pop;

  logic [WIDTH-1:0] res_q   [2];
  logic [RD_W-1:0]  rd_q    [2];
  logic [3:0]       flags_q [2];
  logic [1:0]       wen_q;
  logic [1:0]       ill_q;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    w_opb     = in_use_imm ? in_imm : in_b;
    add_inp1  = '0;
    add_inp2  = '0;
    add_cin   = 1'b0;
    w_wen     = 1'b0;
    w_illegal = 1'b0;
    case (in_op)
      OP_ADD: begin add_inp1 = in_a; add_inp2 = w_opb;  add_cin = 1'b0; w_wen = 1'b1; end
      OP_SUB: begin add_inp1 = in_a; add_inp2 = ~w_opb; add_cin = 1'b1; w_wen = 1'b1; end
      OP_INC: begin add_inp1 = in_a; add_inp2 = '0;     add_cin = 1'b1; w_wen = 1'b1; end
      OP_DEC: begin add_inp1 = in_a; add_inp2 = '1;     add_cin = 1'b0; w_wen = 1'b1; end
      OP_NEG: begin add_inp1 = '0;   add_inp2 = ~w_opb; add_cin = 1'b1; w_wen = 1'b1; end
      OP_CMP: begin add_inp1 = in_a; add_inp2 = ~w_opb; add_cin = 1'b1; w_wen = 1'b0; end
      default: w_illegal = 1'b1;
    endcase
  end

  // Carry-out is reconstructed from the operand and sum MSBs only.
  assign w_n      = add_sum[WIDTH-1];
  assign w_z      = (add_sum == '0);
  assign w_c      = (add_inp1[WIDTH-1] & add_inp2[WIDTH-1]) |
                    ((add_inp1[WIDTH-1] ^ add_inp2[WIDTH-1]) & ~add_sum[WIDTH-1]);
  assign w_v      = (add_inp1[WIDTH-1] == add_inp2[WIDTH-1]) &
                    (add_sum[WIDTH-1] != add_inp1[WIDTH-1]);
  assign w_flags  = w_illegal ? 4'b0000 : {w_n, w_z, w_c, w_v};
  assign w_result = w_illegal ? '0 : add_sum;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    head_d  = head_q ^ w_pop;
    tail_d  = tail_q ^ w_push;
    count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      wen_q   <= 2'b00;
      ill_q   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        res_q[i]   <= '0;
        rd_q[i]    <= '0;
        flags_q[i] <= 4'b0000;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (w_push && !flush) begin
        res_q[tail_q]   <= w_result;
        rd_q[tail_q]    <= in_rd;
        flags_q[tail_q] <= w_flags;
        wen_q[tail_q]   <= w_wen;
        ill_q[tail_q]   <= w_illegal;
      end
    end
  end

  assign out_result  = out_valid ? res_q[head_q]   : '0;
  assign out_rd      = out_valid ? rd_q[head_q]    : '0;
  assign out_flags   = out_valid ? flags_q[head_q] : 4'b0000;
  assign out_wen     = out_valid & wen_q[head_q];
  assign out_illegal = out_valid & ill_q[head_q];

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Function : directed self-checking bench with a behavioural adder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_use_imm, add_cin;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, in_imm, add_inp1, add_inp2, add_sum, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_wen, out_illegal;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign add_sum = add_inp1 + add_inp2 + {31'd0, add_cin};

  alu_operand_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .add_inp1(add_inp1), .add_inp2(add_inp2), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_flags(out_flags), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
    in_op = op; in_a = a; in_b = b; in_imm = imm; in_use_imm = use_imm; in_rd = rd;
    in_valid = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] res, input logic [3:0] fl,
                            input logic wen, input logic ill, input logic [4:0] rd);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(out_result), 64'(res));
    check({tag, "_flags"}, 64'(out_flags), 64'(fl));
    check({tag, "_wen"}, 64'(out_wen), 64'(wen));
    check({tag, "_illegal"}, 64'(out_illegal), 64'(ill));
    check({tag, "_rd"}, 64'(out_rd), 64'(rd));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_result"}, 64'(out_result), 64'd0);
    check({tag, "_rd"}, 64'(out_rd), 64'd0);
    check({tag, "_wen"}, 64'(out_wen), 64'd0);
    check({tag, "_flags"}, 64'(out_flags), 64'd0);
    check({tag, "_illegal"}, 64'(out_illegal), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_a = '0; in_b = '0; in_imm = '0; in_use_imm = 1'b0; in_rd = '0;
    #12;
    check_empty("reset");
    rst_n = 1'b1;
    tick();

    // single ops, one per cycle, consumer always ready
    out_ready = 1'b1;
    issue(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd3);
    tick();
    check_head("add_ovf", 32'h8000_0000, 4'b1001, 1'b1, 1'b0, 5'd3);
    issue(3'b001, 32'd5, 32'd0, 32'd5, 1'b1, 5'd4);
    #1;
    check("sub_inp2", 64'(add_inp2), 64'hFFFF_FFFA);
    check("sub_cin", 64'(add_cin), 64'd1);
    tick();
    check_head("sub_imm", 32'h0, 4'b0110, 1'b1, 1'b0, 5'd4);
    issue(3'b101, 32'd3, 32'd7, 32'd0, 1'b0, 5'd5);
    tick();
    check_head("cmp", 32'hFFFF_FFFC, 4'b1000, 1'b0, 1'b0, 5'd5);
    issue(3'b010, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 5'd6);
    tick();
    check_head("inc", 32'h0, 4'b0110, 1'b1, 1'b0, 5'd6);
    issue(3'b011, 32'd0, 32'd0, 32'd0, 1'b0, 5'd7);
    tick();
    check_head("dec", 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0, 5'd7);
    issue(3'b100, 32'd99, 32'd1, 32'd0, 1'b0, 5'd8);
    tick();
    check_head("neg", 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0, 5'd8);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);

    // backpressure
    out_ready = 1'b0;
    issue(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1);
    tick();
    issue(3'b000, 32'd2, 32'd2, 32'd0, 1'b0, 5'd2);
    tick();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    issue(3'b000, 32'd3, 32'd3, 32'd0, 1'b0, 5'd3);
    tick();
    check("bp_stall_ready", 64'(in_ready), 64'd0);
    check("bp_stall_head", 64'(out_result), 64'd2);
    tick();
    out_ready = 1'b1;
    #1;
    check("bp_head0", 64'(out_result), 64'd2);
    check("bp_pop_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_head1", 64'(out_result), 64'd4);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    check("bp_head2", 64'(out_result), 64'd6);
    check("bp_head2_rd", 64'(out_rd), 64'd3);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // illegal opcode then recovery
    issue(3'b111, 32'd5, 32'd6, 32'd0, 1'b0, 5'd9);
    #1;
    check("ill_inp1", 64'(add_inp1), 64'd0);
    check("ill_inp2", 64'(add_inp2), 64'd0);
    tick();
    check_head("ill", 32'h0, 4'b0000, 1'b0, 1'b1, 5'd9);
    issue(3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 5'd10);
    tick();
    check_head("after_ill", 32'd3, 4'b0000, 1'b1, 1'b0, 5'd10);
    in_valid = 1'b0;
    tick();

    // flush of a full buffer, then flush colliding with a push
    out_ready = 1'b0;
    issue(3'b000, 32'd4, 32'd4, 32'd0, 1'b0, 5'd1);
    tick();
    tick();
    check("fl_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_empty("flush");
    issue(3'b000, 32'd4, 32'd4, 32'd0, 1'b0, 5'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_push_valid", 64'(out_valid), 64'd0);

    // asynchronous reset in the middle of a stall
    issue(3'b000, 32'd8, 32'd8, 32'd0, 1'b0, 5'd2);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_empty("async_rst");
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    issue(3'b000, 32'd10, 32'd20, 32'd0, 1'b0, 5'd11);
    tick();
    check_head("post_rst", 32'd30, 4'b0000, 1'b1, 1'b0, 5'd11);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
